sw_score_collector: RTL and testbench

- Sequences one alignment pass at a time around the 64-lane max-reduction tree.
- Issues the tree's init pulse at pass start and waits out the tree's pipeline drain after the last PE column.
- Captures the final per-pass max score with its sequence ID and queues it in a small FIFO for the host-side result reader, which pops it with a valid/ready handshake.
- Also keeps a running global best (score, ID) across passes.

---
 rtl/sw_score_collector_pkg.sv | 30 +++
 rtl/sw_result_fifo.sv | 79 +++++++
 rtl/sw_score_collector.sv | 157 +++++++++++++++
 tb/tb_sw_score_collector.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_score_collector_pkg.sv
// ============================================================================
// Module  : sw_score_collector_pkg
// Purpose : Shared types and constants for the Smith-Waterman score
//           collector: FSM state encoding and the default sequence-ID width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

// Score width is normally provided globally by the core's defines; this
// fallback keeps the block self-contained when compiled on its own.
`ifndef V_E_F_Bit
`define V_E_F_Bit 12
`endif

package sw_score_collector_pkg;

  localparam int SW_ID_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4
  } sw_state_e;

endpackage

`default_nettype wire

// File: rtl/sw_result_fifo.sv
// ============================================================================
// Module  : sw_result_fifo
// Purpose : Small synchronous FIFO holding {score, id} results. The head
//           entry is presented combinationally and reads as zero when empty.
// Ports   : clk, rst_n        - clock, async active-low reset
//           push, push_data   - write request and data
//           pop               - remove head entry
//           head_data         - current head (0 when empty)
//           count, full, empty- occupancy status
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_result_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still legal when the head leaves this cycle:
  // the write lands in the slot being vacated.
  assign do_push = push & (~full | do_pop);

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sw_score_collector.sv
// ============================================================================
// Module  : sw_score_collector
// Purpose : Sequences one alignment pass around the max-reduction tree:
//           pulses max_init, waits for the last PE column plus the tree
//           drain, captures the clamped pass max with its ID into a result
//           FIFO, and tracks the global best (score, ID) across passes.
// Ports   : pass_start/pass_id/start_ready - pass request handshake
//           pass_done, max_result          - tree inputs
//           max_init, busy                 - tree clear, pass in flight
//           out_valid/out_ready/out_score/out_id - result FIFO head
//           best_score, best_id, clear_best - global best tracking
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_score_collector
  import sw_score_collector_pkg::*;
#(
  parameter int DATA_WIDTH   = `V_E_F_Bit,
  parameter int ID_WIDTH     = SW_ID_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pass_start,
  input  logic [ID_WIDTH-1:0]   pass_id,
  output logic                  start_ready,
  input  logic                  pass_done,
  input  logic [DATA_WIDTH-1:0] max_result,
  output logic                  max_init,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_score,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [DATA_WIDTH-1:0] best_score,
  output logic [ID_WIDTH-1:0]   best_id,
  input  logic                  clear_best
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  // DRAIN holds for DRAIN_CYCLES-1 cycles, counting 0 .. DRAIN_CYCLES-2.
  localparam logic [DCW-1:0] C_DRAIN_LAST =
    DCW'((DRAIN_CYCLES > 1) ? (DRAIN_CYCLES - 2) : 0);
  localparam int FW = DATA_WIDTH + ID_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sw_state_e             state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
  logic                  max_init_q, max_init_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] best_score_q, best_score_d;
  logic [ID_WIDTH-1:0]   best_id_q, best_id_d;

  logic [DATA_WIDTH-1:0] cap_score;
  logic                  capture;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [FW-1:0]         fifo_head;

  // A negative tree result means no positive local alignment was found.
  assign cap_score   = max_result[DATA_WIDTH-1] ? '0 : max_result;
  assign capture     = (state_q == ST_CAPTURE);
  assign start_ready = (state_q == ST_IDLE) && (fifo_count < CW'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pass_start && start_ready) begin
          id_d    = pass_id;
          state_d = ST_INIT;
        end
      end
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (pass_done) begin
          drain_cnt_d = '0;
          state_d     = (DRAIN_CYCLES == 1) ? ST_CAPTURE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == C_DRAIN_LAST) state_d = ST_CAPTURE;
        else                             drain_cnt_d = drain_cnt_q + DCW'(1);
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Outputs are registered against the next state so they align with it.
    max_init_d = (state_d == ST_INIT);
    busy_d     = (state_d != ST_IDLE);
  end

  always_comb begin
    best_score_d = best_score_q;
    best_id_d    = best_id_q;
    if (clear_best) begin
      best_score_d = '0;
      best_id_d    = '0;
    end else if (capture && (cap_score > best_score_q)) begin
      // Strictly greater: ties keep the earlier pass's ID.
      best_score_d = cap_score;
      best_id_d    = id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      drain_cnt_q  <= '0;
      max_init_q   <= 1'b0;
      busy_q       <= 1'b0;
      best_score_q <= '0;
      best_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      drain_cnt_q  <= drain_cnt_d;
      max_init_q   <= max_init_d;
      busy_q       <= busy_d;
      best_score_q <= best_score_d;
      best_id_q    <= best_id_d;
    end
  end

  // Admission guarantees a free slot at capture; the full gate is defensive.
  sw_result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture & ~fifo_full),
    .push_data ({cap_score, id_q}),
    .pop       (out_valid & out_ready),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign out_score  = fifo_head[FW-1:ID_WIDTH];
  assign out_id     = fifo_head[ID_WIDTH-1:0];
  assign max_init   = max_init_q;
  assign busy       = busy_q;
  assign best_score = best_score_q;
  assign best_id    = best_id_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_score_collector.sv
// ============================================================================
// Module  : tb_sw_score_collector
// Purpose : Self-checking bench for sw_score_collector (DATA_WIDTH=12,
//           DRAIN_CYCLES=2, FIFO_DEPTH=4) using a table of pass records and
//           hand-written sequences for the multi-cycle corner cases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_score_collector;

  localparam int DW = 12;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pass_start;
  logic [IW-1:0] pass_id;
  logic          start_ready;
  logic          pass_done;
  logic [DW-1:0] max_result;
  logic          max_init;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_score;
  logic [IW-1:0] out_id;
  logic [DW-1:0] best_score;
  logic [IW-1:0] best_id;
  logic          clear_best;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] max_res;
    logic [DW-1:0] exp_score;
    logic [DW-1:0] exp_best;
    logic [IW-1:0] exp_best_id;
  } pass_vec_t;

  pass_vec_t vecs [7];

  always #5 clk = ~clk;

  sw_score_collector #(
    .DATA_WIDTH   (DW),
    .ID_WIDTH     (IW),
    .FIFO_DEPTH   (4),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pass_start  (pass_start),
    .pass_id     (pass_id),
    .start_ready (start_ready),
    .pass_done   (pass_done),
    .max_result  (max_result),
    .max_init    (max_init),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_score   (out_score),
    .out_id      (out_id),
    .best_score  (best_score),
    .best_id     (best_id),
    .clear_best  (clear_best)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One full pass: start, two RUN cycles, pass_done, then wait for IDLE.
  task automatic do_pass(input logic [IW-1:0] id, input logic [DW-1:0] score);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin tick(); n++; end
    check("wait_start_ready", start_ready, 1);
    pass_start = 1'b1; pass_id = id;
    tick();                           // INIT
    pass_start = 1'b0;
    tick();                           // RUN
    max_result = score;
    tick();
    pass_done = 1'b1;
    tick();                           // DRAIN
    pass_done = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("wait_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; pass_start = 1'b0; pass_id = '0; pass_done = 1'b0;
    max_result = '0; out_ready = 1'b0; clear_best = 1'b0;

    vecs[0] = '{16'd10, 12'd10,  12'd10, 12'd10, 16'd10};
    vecs[1] = '{16'd11, 12'd30,  12'd30, 12'd30, 16'd11};
    vecs[2] = '{16'd12, 12'd20,  12'd20, 12'd30, 16'd11};
    vecs[3] = '{16'd13, 12'd40,  12'd40, 12'd40, 16'd13};
    vecs[4] = '{16'd1,  12'd50,  12'd50, 12'd50, 16'd1};
    vecs[5] = '{16'd2,  12'd50,  12'd50, 12'd50, 16'd1};
    vecs[6] = '{16'd3,  12'h800, 12'd0,  12'd50, 16'd1};

    // Reset values
    tick(); tick();
    check("rst_max_init", max_init, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_score", out_score, 0);
    check("rst_out_id", out_id, 0);
    check("rst_best_score", best_score, 0);
    check("rst_best_id", best_id, 0);
    check("rst_start_ready", start_ready, 1);
    rst_n = 1'b1;
    tick();

    // Basic pass with cycle-exact timing
    for (int c = 0; c <= 13; c++) begin
      pass_start = (c == 0);
      pass_id    = 16'd5;
      pass_done  = (c == 10);
      if (c == 2) max_result = 12'h07B;
      check($sformatf("basic_max_init_c%0d", c), max_init, (c == 1));
      check($sformatf("basic_busy_c%0d", c), busy, (c >= 1 && c <= 12));
      check($sformatf("basic_out_valid_c%0d", c), out_valid, (c >= 13));
      tick();
    end
    pass_start = 1'b0; pass_done = 1'b0;
    check("basic_out_score", out_score, 12'h07B);
    check("basic_out_id", out_id, 5);
    check("basic_best_score", best_score, 12'h07B);
    check("basic_best_id", best_id, 5);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("basic_popped", out_valid, 0);

    // Backpressure: four passes with no consumer
    clear_best = 1'b1; tick(); clear_best = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_pass(vecs[i].id, vecs[i].max_res);
      check($sformatf("bp_best_score_%0d", i), best_score, vecs[i].exp_best);
      check($sformatf("bp_best_id_%0d", i), best_id, vecs[i].exp_best_id);
    end
    check("bp_full_start_ready", start_ready, 0);
    pass_start = 1'b1; pass_id = 16'd99;
    tick();
    pass_start = 1'b0;
    check("bp_ignored_busy", busy, 0);
    tick();
    check("bp_ignored_busy2", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_pop_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_pop_score_%0d", i), out_score, vecs[i].exp_score);
      check($sformatf("bp_pop_id_%0d", i), out_id, vecs[i].id);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (i == 0) check("bp_ready_after_pop", start_ready, 1);
    end
    check("bp_drained", out_valid, 0);

    // Tie and clamp
    clear_best = 1'b1; tick(); clear_best = 1'b0;
    check("tc_cleared", best_score, 0);
    for (int i = 4; i < 7; i++) begin
      do_pass(vecs[i].id, vecs[i].max_res);
      check($sformatf("tc_best_score_%0d", i), best_score, vecs[i].exp_best);
      check($sformatf("tc_best_id_%0d", i), best_id, vecs[i].exp_best_id);
    end
    for (int i = 4; i < 7; i++) begin
      check($sformatf("tc_pop_score_%0d", i), out_score, vecs[i].exp_score);
      check($sformatf("tc_pop_id_%0d", i), out_id, vecs[i].id);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    check("tc_drained", out_valid, 0);

    // clear_best coinciding with CAPTURE of score 99
    pass_start = 1'b1; pass_id = 16'd20;
    tick();                           // INIT
    pass_start = 1'b0;
    tick();                           // RUN
    max_result = 12'd99; pass_done = 1'b1;
    tick();                           // DRAIN
    pass_done = 1'b0;
    tick();                           // CAPTURE
    check("clr_in_capture_busy", busy, 1);
    clear_best = 1'b1;
    tick();
    clear_best = 1'b0;
    check("clr_best_score", best_score, 0);
    check("clr_best_id", best_id, 0);
    check("clr_fifo_valid", out_valid, 1);
    check("clr_fifo_score", out_score, 99);
    check("clr_fifo_id", out_id, 20);

    // Push and pop in the same cycle with one entry queued
    pass_start = 1'b1; pass_id = 16'd8;
    tick();
    pass_start = 1'b0;
    tick();
    max_result = 12'd7; pass_done = 1'b1;
    tick();
    pass_done = 1'b0;
    tick();                           // CAPTURE
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_valid", out_valid, 1);
    check("pp_score", out_score, 7);
    check("pp_id", out_id, 8);
    check("pp_best", best_score, 7);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("pp_count_was_one", out_valid, 0);

    // pass_done in IDLE and INIT, pass_start in RUN
    pass_done = 1'b1; tick(); pass_done = 1'b0; tick();
    check("pd_idle_busy", busy, 0);
    check("pd_idle_valid", out_valid, 0);
    pass_start = 1'b1; pass_id = 16'd30;
    tick();                           // INIT
    pass_start = 1'b0; pass_done = 1'b1;
    check("pd_init_max_init", max_init, 1);
    tick();                           // RUN
    pass_done = 1'b0;
    tick(); tick();
    check("pd_init_still_busy", busy, 1);
    check("pd_init_no_capture", out_valid, 0);
    pass_start = 1'b1; pass_id = 16'd77;
    tick();
    pass_start = 1'b0; max_result = 12'd3; pass_done = 1'b1;
    tick();                           // DRAIN
    pass_done = 1'b0;
    tick(); tick();                   // CAPTURE, IDLE
    check("ps_run_valid", out_valid, 1);
    check("ps_run_id", out_id, 30);
    check("ps_run_score", out_score, 3);
    check("ps_run_best_kept", best_id, 8);

    // Asynchronous reset while in DRAIN, with an entry queued
    pass_start = 1'b1; pass_id = 16'd40;
    tick();
    pass_start = 1'b0;
    tick();
    max_result = 12'd60; pass_done = 1'b1;
    tick();                           // DRAIN
    pass_done = 1'b0;
    check("ar_in_drain_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_max_init", max_init, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_out_score", out_score, 0);
    check("ar_out_id", out_id, 0);
    check("ar_best_score", best_score, 0);
    check("ar_best_id", best_id, 0);
    check("ar_start_ready", start_ready, 1);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("ar_after_busy", busy, 0);
    check("ar_after_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
